thunder_cfg_sequencer: RTL and testbench
========================================

Name: thunder_cfg_sequencer

Overview:
- Configures the Thunderbolt GPS at power-up by sending TSIP command packets over the shared UART transmitter.
- Confirms each command by watching the UART receive byte stream for the matching 8F report.
- Retries a command on timeout and flags an error after repeated failures.
- Gates the downstream 8F-AB timing-packet receiver through o_rx_enable, so timing data is used only after configuration succeeds.

Parameters:
- BOOT_DELAY_CLKS, 10000: idle clocks after reset before the first byte is sent.
- ACK_TIMEOUT_CLKS, 5000000: clocks to wait for a report after a packet's last byte (0.5 s at 10 MHz).
- MAX_RETRIES, 3: retransmissions allowed per packet before error.
- BCAST_MASK_B1, 8'h01: second mask byte of the 8E-A5 packet.

Ports:
- i_clk, in, 1: system clock (10 MHz).
- i_rst_n, in, 1: reset, synchronous, active-low.
- i_start, in, 1: one-cycle restart request; honoured only in DONE or ERROR.
- o_tx_dv, out, 1: one-cycle strobe to uart_tx.
- o_tx_byte, out, 8: byte to transmit; held stable from o_tx_dv until i_tx_done.
- i_tx_done, in, 1: uart_tx byte-complete pulse.
- i_rx_dv, in, 1: uart_rx byte-valid pulse.
- i_rx_byte, in, 8: uart_rx byte.
- o_cfg_done, out, 1: all packets acknowledged (level).
- o_cfg_error, out, 1: retries exhausted (level).
- o_rx_enable, out, 1: enables the timing-packet receiver; equals o_cfg_done.
- o_retry_count, out, 2: retries used on the current packet.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State goes to BOOT_WAIT.
  - All outputs are 0, except o_tx_byte = 8'h10.
  - Counters and the packet index are cleared.
  - Reset mid-transmission abandons the packet immediately; o_tx_dv is never asserted during reset.
- Packet list (payload shown; framing added by hardware):
  - P0 = 8E A2 01, expects report 8F A2.
  - P1 = 8E A5 00 BCAST_MASK_B1 00 00, expects report 8F A5.
- Wire framing:
  - Frame is DLE(10), payload, DLE(10), ETX(03).
  - Any payload byte equal to 8'h10 is sent twice (stuffing).
- States:
  - BOOT_WAIT: counts BOOT_DELAY_CLKS cycles, then goes to SEND.
  - SEND: drives o_tx_byte, pulses o_tx_dv for exactly 1 cycle, then goes to WAIT_TX.
  - WAIT_TX: waits for i_tx_done. If more bytes remain, goes to SEND on the next cycle (one idle cycle between bytes). After ETX, clears the timeout counter and goes to WAIT_ACK.
  - WAIT_ACK: on an ack, clears o_retry_count and advances the packet index; after the last packet goes to DONE, otherwise to SEND. If the counter reaches ACK_TIMEOUT_CLKS-1 without an ack: when o_retry_count == MAX_RETRIES go to ERROR, else increment o_retry_count and resend the same packet from its leading DLE.
  - DONE: o_cfg_done=1 and o_rx_enable=1.
  - ERROR: o_cfg_error=1.
- Restart: i_start in DONE or ERROR clears both flags, the index and the retries, then goes directly to SEND P0 (no boot delay). i_start in any other state is ignored.
- Ack detector (active in all states; matches only in WAIT_ACK):
  - dle_odd toggles on each received 10 and clears on any other byte.
  - Receiving 8F while dle_odd=1 arms the detector.
  - If the next byte equals the expected subcode, ack=1 for one cycle. Any other next byte disarms.
  - A stuffed 10 10 never arms the detector.
- Simultaneous events:
  - An ack on the same cycle as the timeout takes priority (the packet counts as acknowledged).
  - An i_rx_dv that arrives during SEND or WAIT_TX still updates the detector, but an ack completed outside WAIT_ACK is discarded.
- Widths:
  - The timeout counter is wide enough for ACK_TIMEOUT_CLKS and saturates, never wraps.
  - o_retry_count saturates at MAX_RETRIES.

Optional Feature:
- Macro: THUNDER_CFG_SURVEY_EN.
- Defined: appends P2 = 8E A6 00 (restart self-survey), expecting report 8F A6; DONE is reached only after P2 is acknowledged.
- Undefined: sequence is P0 and P1 only; no P2 logic is synthesised.

Test Plan:
- Reset release with BOOT_DELAY_CLKS=16 and ACK_TIMEOUT_CLKS=2000; tx model answers after every ETX -> first o_tx_dv comes 16 cycles after reset; bytes are exactly 10 8E A2 01 10 03; no o_tx_dv before 16.
- Rx model replies 10 8F A2 ... 10 03, then 10 8F A5 ... 10 03 -> P1 bytes are 10 8E A5 00 01 00 00 10 03; o_cfg_done=o_rx_enable=1 one cycle after the A5 byte.
- No rx replies at all -> P0 sent 4 times; o_retry_count steps 0,1,2,3; o_cfg_error=1 exactly 2000 cycles after the 4th ETX completes.
- BCAST_MASK_B1=8'h10 -> P1 wire is 10 8E A5 00 10 10 00 00 10 03 (10 bytes). Rx stream 10 10 8F A5 must not ack; a following 10 8F A5 must ack.
- From ERROR, pulse i_start -> flags clear; P0 leading DLE is sent 1 cycle later with no boot delay. An i_start pulsed during WAIT_TX has no effect.
- Assert i_rst_n=0 mid-P1 byte 5, then release -> outputs return to reset values and the sequence restarts at BOOT_WAIT with P0.

Source files
------------

// File: rtl/thunder_cfg_sequencer.sv
// Power-up TSIP configuration of the Thunderbolt GPS: frames 8E packets onto the shared UART,
// waits for the matching 8F report, retries on timeout. Define THUNDER_CFG_SURVEY_EN to append 8E-A6.
module thunder_cfg_sequencer #(
    parameter int unsigned BOOT_DELAY_CLKS  = 10000,
    parameter int unsigned ACK_TIMEOUT_CLKS = 5000000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter logic [7:0]  BCAST_MASK_B1    = 8'h01
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_cfg_done,
    output logic       o_cfg_error,
    output logic       o_rx_enable,
    output logic [1:0] o_retry_count
);
    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;
    localparam logic [7:0] RPT = 8'h8F;
`ifdef THUNDER_CFG_SURVEY_EN
    localparam int unsigned NUM_PKTS = 3;
`else
    localparam int unsigned NUM_PKTS = 2;
`endif
    localparam int unsigned BW = $clog2(BOOT_DELAY_CLKS + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT_CLKS + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_DELAY_CLKS - 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] ACK_MAX   = TW'(ACK_TIMEOUT_CLKS);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);
    localparam logic [1:0]    PKT_LAST  = 2'(NUM_PKTS - 1);

    typedef enum logic [2:0] {BOOT_WAIT, SEND, WAIT_TX, WAIT_ACK, DONE, ERROR} state_t;
    state_t state, state_nx;

    logic [BW-1:0] boot_cnt;
    logic [TW-1:0] ack_cnt;
    logic [1:0]    pkt_idx;
    logic [3:0]    pos;        // 0 lead DLE, 1..len payload, len+1 trailing DLE, len+2 ETX
    logic          stuff_pend; // current payload DLE has gone out once, its copy is next
    logic          dle_odd;
    logic          armed;

    logic [3:0] pay_len;
    logic [7:0] pay_byte;
    logic [7:0] exp_sub;
    logic       is_pay, last_byte, ack, ack_hit, timeout;

    always_comb begin
        pay_len  = 4'd3;
        pay_byte = 8'h00;
        exp_sub  = 8'hA2;
        case (pkt_idx)
            2'd0: begin
                exp_sub = 8'hA2;
                case (pos)
                    4'd1:    pay_byte = 8'h8E;
                    4'd2:    pay_byte = 8'hA2;
                    4'd3:    pay_byte = 8'h01;
                    default: pay_byte = 8'h00;
                endcase
            end
            2'd1: begin
                pay_len = 4'd6;
                exp_sub = 8'hA5;
                case (pos)
                    4'd1:    pay_byte = 8'h8E;
                    4'd2:    pay_byte = 8'hA5;
                    4'd4:    pay_byte = BCAST_MASK_B1;
                    default: pay_byte = 8'h00;
                endcase
            end
`ifdef THUNDER_CFG_SURVEY_EN
            2'd2: begin
                exp_sub = 8'hA6;
                case (pos)
                    4'd1:    pay_byte = 8'h8E;
                    4'd2:    pay_byte = 8'hA6;
                    default: pay_byte = 8'h00;
                endcase
            end
`endif
            default: ;
        endcase
    end

    assign is_pay    = (pos != 4'd0) && (pos <= pay_len);
    assign last_byte = (pos == pay_len + 4'd2);
    assign ack       = i_rx_dv && armed && (i_rx_byte == exp_sub);
    assign ack_hit   = ack && (state == WAIT_ACK);
    assign timeout   = (ack_cnt == ACK_LAST);

    always_comb begin
        if (pos == 4'd0 || pos == pay_len + 4'd1) o_tx_byte = DLE;
        else if (is_pay)                          o_tx_byte = pay_byte;
        else                                      o_tx_byte = ETX;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT_WAIT: if (boot_cnt == BOOT_LAST) state_nx = SEND;
            SEND:      state_nx = WAIT_TX;
            WAIT_TX:   if (i_tx_done) state_nx = last_byte ? WAIT_ACK : SEND;
            WAIT_ACK: begin
                // an ack landing on the timeout cycle still counts
                if (ack_hit)      state_nx = (pkt_idx == PKT_LAST) ? DONE : SEND;
                else if (timeout) state_nx = (o_retry_count == RETRY_MAX) ? ERROR : SEND;
            end
            DONE, ERROR: if (i_start) state_nx = SEND;
            default:   state_nx = BOOT_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= BOOT_WAIT;
        else          state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            boot_cnt      <= '0;
            ack_cnt       <= '0;
            pkt_idx       <= '0;
            pos           <= '0;
            stuff_pend    <= 1'b0;
            o_retry_count <= '0;
        end else begin
            boot_cnt <= (state == BOOT_WAIT) ? boot_cnt + BW'(1) : '0;
            case (state)
                WAIT_TX: if (i_tx_done) begin
                    if (last_byte) begin
                        pos     <= '0;
                        ack_cnt <= '0;
                    end else if (is_pay && pay_byte == DLE && !stuff_pend) begin
                        stuff_pend <= 1'b1;
                    end else begin
                        stuff_pend <= 1'b0;
                        pos        <= pos + 4'd1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit) begin
                        o_retry_count <= '0;
                        if (pkt_idx != PKT_LAST) pkt_idx <= pkt_idx + 2'd1;
                    end else if (timeout) begin
                        if (o_retry_count < RETRY_MAX) o_retry_count <= o_retry_count + 2'd1;
                    end else if (ack_cnt != ACK_MAX) begin
                        ack_cnt <= ack_cnt + TW'(1);
                    end
                end
                DONE, ERROR: if (i_start) begin
                    pkt_idx       <= '0;
                    o_retry_count <= '0;
                    pos           <= '0;
                    stuff_pend    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Report detector: an 8F only arms after an unstuffed (odd-count) DLE run.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dle_odd <= 1'b0;
            armed   <= 1'b0;
        end else if (i_rx_dv) begin
            dle_odd <= (i_rx_byte == DLE) ? !dle_odd : 1'b0;
            armed   <= !armed && dle_odd && (i_rx_byte == RPT);
        end
    end

    assign o_tx_dv     = i_rst_n && (state == SEND);
    assign o_cfg_done  = i_rst_n && (state == DONE);
    assign o_cfg_error = i_rst_n && (state == ERROR);
    assign o_rx_enable = o_cfg_done;

endmodule

// File: tb/tb_thunder_cfg_sequencer.sv
// Two sequencers (mask 01 and mask 10) against randomized UART tx/rx models and a frame-level
// reference built from the packet list and stuffing rule.
module tb_thunder_cfg_sequencer;
    localparam int BOOT = 16;
    localparam int TMO  = 2000;
`ifdef THUNDER_CFG_SURVEY_EN
    localparam int NPK = 3;
`else
    localparam int NPK = 2;
`endif
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst_n = 2'b00;
    logic [1:0] start = 2'b00;
    logic [1:0] tx_done = 2'b00;
    logic [1:0] rx_dv = 2'b00;
    logic [1:0] tx_dv, cfg_done, cfg_error, rx_en;
    logic [7:0] tx_byte [2];
    logic [7:0] rx_byte [2];
    logic [1:0] retry [2];

    thunder_cfg_sequencer #(.BOOT_DELAY_CLKS(BOOT), .ACK_TIMEOUT_CLKS(TMO), .MAX_RETRIES(3),
                            .BCAST_MASK_B1(8'h01)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .o_tx_dv(tx_dv[0]),
        .o_tx_byte(tx_byte[0]), .i_tx_done(tx_done[0]), .i_rx_dv(rx_dv[0]), .i_rx_byte(rx_byte[0]),
        .o_cfg_done(cfg_done[0]), .o_cfg_error(cfg_error[0]), .o_rx_enable(rx_en[0]),
        .o_retry_count(retry[0]));

    thunder_cfg_sequencer #(.BOOT_DELAY_CLKS(BOOT), .ACK_TIMEOUT_CLKS(TMO), .MAX_RETRIES(3),
                            .BCAST_MASK_B1(8'h10)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .o_tx_dv(tx_dv[1]),
        .o_tx_byte(tx_byte[1]), .i_tx_done(tx_done[1]), .i_rx_dv(rx_dv[1]), .i_rx_byte(rx_byte[1]),
        .o_cfg_done(cfg_done[1]), .o_cfg_error(cfg_error[1]), .o_rx_enable(rx_en[1]),
        .o_retry_count(retry[1]));

    bit         auto_ack [2];
    bit         trap [2];
    int         txw [2];
    int         rxgap [2];
    int         etx_cyc [2];
    int         sub_cyc [2];
    int         hold_bad [2];
    logic [7:0] txb [2];
    logic [7:0] txq [2][$];
    logic [7:0] cur [2][$];
    logic [8:0] rxq [2][$];

    int checks = 0;
    int errors = 0;

    // reply to a frame: 10 8F sub data data 10 03; bit 8 marks the byte that completes the ack
    function automatic void queue_reply(int d, logic [7:0] sub);
        if (trap[d] && sub == 8'hA5) begin
            rxq[d].push_back(9'h010); rxq[d].push_back(9'h010);
            rxq[d].push_back(9'h08F); rxq[d].push_back(9'h0A5);
        end
        rxq[d].push_back(9'h010); rxq[d].push_back(9'h08F); rxq[d].push_back({1'b1, sub});
        repeat (2) rxq[d].push_back({1'b0, 8'($urandom_range(32, 126))});
        rxq[d].push_back(9'h010); rxq[d].push_back(9'h003);
    endfunction

    // UART tx/rx models, driven away from the active edge
    always @(negedge clk) begin
        logic [8:0] v;
        for (int d = 0; d < 2; d++) begin
            tx_done[d] = 1'b0;
            rx_dv[d]   = 1'b0;
            if (rst_n[d] !== 1'b1) begin
                txw[d] = 0; rxgap[d] = 0;
                rxq[d].delete(); cur[d].delete();
            end else begin
                if (rxgap[d] > 0) rxgap[d]--;
                else if (rxq[d].size() > 0) begin
                    v = rxq[d].pop_front();
                    rx_dv[d] = 1'b1; rx_byte[d] = v[7:0];
                    if (v[8]) sub_cyc[d] = cyc + 1;
                    rxgap[d] = $urandom_range(0, 2);
                end
                if (tx_dv[d] === 1'b1) begin
                    txq[d].push_back(tx_byte[d]); cur[d].push_back(tx_byte[d]);
                    txb[d] = tx_byte[d];
                    txw[d] = $urandom_range(1, 4);
                end else if (txw[d] > 0) begin
                    txw[d]--;
                    if (txw[d] == 0) begin
                        if (tx_byte[d] !== txb[d]) hold_bad[d]++;
                        tx_done[d] = 1'b1;
                        if (txb[d] == 8'h03) begin
                            etx_cyc[d] = cyc + 1;
                            if (auto_ack[d] && cur[d].size() > 2) queue_reply(d, cur[d][2]);
                            cur[d].delete();
                        end
                    end
                end
            end
        end
    end

    function automatic bq_t frame(int p, logic [7:0] m);
        bq_t pl, f;
        if (p == 0)      pl = {8'h8E, 8'hA2, 8'h01};
        else if (p == 1) pl = {8'h8E, 8'hA5, 8'h00, m, 8'h00, 8'h00};
        else             pl = {8'h8E, 8'hA6, 8'h00};
        f.push_back(8'h10);
        foreach (pl[i]) begin
            f.push_back(pl[i]);
            if (pl[i] == 8'h10) f.push_back(8'h10);
        end
        f.push_back(8'h10); f.push_back(8'h03);
        return f;
    endfunction

    function automatic bq_t seq_of(int first, int count, logic [7:0] m);
        bq_t q, t;
        for (int k = 0; k < count; k++) begin
            t = frame((first < 0) ? k : first, m);
            foreach (t[i]) q.push_back(t[i]);
        end
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic chk_stream(input string tag, input int d, input int base, input bq_t e);
        int bad;
        bad = -1;
        for (int i = 0; i < e.size(); i++)
            if (bad < 0 && (base + i >= txq[d].size() || txq[d][base + i] !== e[i])) bad = i;
        chk({tag, "_len"}, txq[d].size() - base, e.size());
        chk({tag, "_first_bad_idx"}, bad, -1);
    endtask

    task automatic check_reset(input int d);
        chk($sformatf("rst_tx_dv_%0d", d), tx_dv[d], 1'b0);
        chk($sformatf("rst_tx_byte_%0d", d), tx_byte[d], 8'h10);
        chk($sformatf("rst_done_%0d", d), cfg_done[d], 1'b0);
        chk($sformatf("rst_error_%0d", d), cfg_error[d], 1'b0);
        chk($sformatf("rst_rx_en_%0d", d), rx_en[d], 1'b0);
        chk($sformatf("rst_retry_%0d", d), retry[d], 2'd0);
    endtask

    task automatic wait_first_dv(input int d, input int rel);
        int n;
        n = 0;
        do begin step(); n++; end while (tx_dv[d] !== 1'b1 && n < 100);
        chk($sformatf("first_dv_delay_%0d", d), cyc - rel, BOOT);
        chk($sformatf("first_byte_dle_%0d", d), tx_byte[d], 8'h10);
    endtask

    task automatic wait_done(input int d, output int at);
        int n;
        n = 0;
        while (cfg_done[d] !== 1'b1 && n < 20000) begin step(); n++; end
        at = cyc;
        chk($sformatf("done_reached_%0d", d), n < 20000, 1'b1);
        chk($sformatf("done_rx_en_%0d", d), rx_en[d], 1'b1);
        chk($sformatf("done_err_low_%0d", d), cfg_error[d], 1'b0);
    endtask

    initial begin
        int base, rel, at, n;
        logic [1:0]  prv;
        logic [15:0] rseq;

        repeat (3) step();
        check_reset(0);
        check_reset(1);

        // power-up sequence with a responsive receiver
        auto_ack[0] = 1'b1;
        base = txq[0].size();
        rst_n[0] = 1'b1; rel = cyc;
        wait_first_dv(0, rel);
        wait_done(0, at);
        chk("powerup_done_after_ack", at, sub_cyc[0]);
        chk("powerup_retry", retry[0], 2'd0);
        chk_stream("powerup", 0, base, seq_of(-1, NPK, 8'h01));

        // restart from DONE, receiver silent: P0 four times then ERROR
        auto_ack[0] = 1'b0;
        base = txq[0].size();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        chk("restart_done_dv", tx_dv[0], 1'b1);
        chk("restart_done_clr", cfg_done[0], 1'b0);
        chk("restart_rx_en_clr", rx_en[0], 1'b0);
        start[0] = 1'b1; step(); start[0] = 1'b0;   // lands in WAIT_TX
        rseq = 16'h0; prv = retry[0]; n = 0;
        while (cfg_error[0] !== 1'b1 && n < 12000) begin
            step(); n++;
            if (retry[0] !== prv) begin prv = retry[0]; rseq = {rseq[11:0], 2'b00, prv}; end
        end
        at = cyc;
        chk("error_reached", n < 12000, 1'b1);
        chk("retry_steps", rseq, 16'h0123);
        chk("error_delay", at - etx_cyc[0], TMO);
        chk("error_retry_sat", retry[0], 2'd3);
        chk("error_done_low", cfg_done[0], 1'b0);
        chk_stream("retries", 0, base, seq_of(0, 4, 8'h01));

        // restart from ERROR
        auto_ack[0] = 1'b1;
        base = txq[0].size();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        chk("restart_err_dv", tx_dv[0], 1'b1);
        chk("restart_err_byte", tx_byte[0], 8'h10);
        chk("restart_err_clr", cfg_error[0], 1'b0);
        chk("restart_err_retry", retry[0], 2'd0);
        wait_done(0, at);
        chk("rerun_done_after_ack", at, sub_cyc[0]);
        chk_stream("rerun", 0, base, seq_of(-1, NPK, 8'h01));

        // stuffed mask byte and a stuffed DLE ahead of 8F in the report stream
        auto_ack[1] = 1'b1; trap[1] = 1'b1;
        base = txq[1].size();
        rst_n[1] = 1'b1; rel = cyc;
        wait_first_dv(1, rel);
        wait_done(1, at);
        chk("stuffed_dle_no_ack", at, sub_cyc[1]);
        chk_stream("mask10", 1, base, seq_of(-1, NPK, 8'h10));

        // reset mid-P1 (fifth byte on the wire)
        base = txq[0].size();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        n = 0;
        while (!(tx_dv[0] === 1'b1 && txq[0].size() == base + 11) && n < 5000) begin step(); n++; end
        chk("reached_p1_byte5", n < 5000, 1'b1);
        rst_n[0] = 1'b0; #1;
        chk("dv_gated_in_reset", tx_dv[0], 1'b0);
        repeat (2) step();
        check_reset(0);
        base = txq[0].size();
        rst_n[0] = 1'b1; rel = cyc;
        wait_first_dv(0, rel);
        wait_done(0, at);
        chk_stream("after_reset", 0, base, seq_of(-1, NPK, 8'h01));

        chk("tx_byte_hold_0", hold_bad[0], 0);
        chk("tx_byte_hold_1", hold_bad[1], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
